// File: rtl/game_pkg.sv
// game_pkg: shared strategy, state, result and control-code definitions for the counter-game player.
package game_pkg;

    typedef enum logic [1:0] {
        FIXED    = 2'd0,
        AIM_WIN  = 2'd1,
        AIM_LOSE = 2'd2,
        BOUNCE   = 2'd3
    } strategy_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        PLAY = 2'd2,
        DONE = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        NONE    = 2'b00,
        LOST    = 2'b01,
        WON     = 2'b10,
        TIMEOUT = 2'b11
    } result_e;

    localparam logic [1:0] UP1 = 2'b00;
    localparam logic [1:0] UP2 = 2'b01;
    localparam logic [1:0] DN1 = 2'b10;
    localparam logic [1:0] DN2 = 2'b11;

    // Control code driven from LOAD onwards, before any win/loss feedback.
    function automatic logic [1:0] initial_code(strategy_e s, logic [1:0] fixed_code);
        return s == FIXED ? fixed_code : s == AIM_LOSE ? DN1 : UP1;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// sat_counter: event counter that sticks at all-ones, with synchronous clear.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (inc && cnt != '1)
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/game_player.sv
// game_player: autonomous driver for the counter game; plays one game with a chosen strategy and reports the outcome.
module game_player
    import game_pkg::*;
#(
    parameter int COUNTER_SIZE = 4,
    parameter int MAX_CYCLES   = 1024,
    parameter int EVT_W        = 8
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic                    stop,
    input  logic [1:0]              strategy,
    input  logic [1:0]              fixed_ctrl,
    input  logic [COUNTER_SIZE-1:0] seed,
    input  logic                    win,
    input  logic                    los,
    input  logic                    gameover,
    input  logic [1:0]              who,
    output logic [1:0]              control,
    output logic                    INIT,
    output logic [COUNTER_SIZE-1:0] i_value,
    output logic                    busy,
    output logic                    done,
    output logic [1:0]              result,
    output logic [EVT_W-1:0]        win_cnt,
    output logic [EVT_W-1:0]        los_cnt
);

    localparam int CW = MAX_CYCLES > 2 ? $clog2(MAX_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(MAX_CYCLES - 1);

    state_e        state;
    strategy_e     strat;
    logic [CW-1:0] cyc;
    logic          clr;
    logic          play;

    assign clr  = state == IDLE && start;
    assign play = state == PLAY;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            strat   <= FIXED;
            cyc     <= '0;
            control <= UP1;
            INIT    <= 1'b0;
            i_value <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= NONE;
        end else begin
            unique case (state)
                IDLE: if (start) begin
                    strat   <= strategy_e'(strategy);
                    cyc     <= '0;
                    result  <= NONE;
                    INIT    <= 1'b1;
                    i_value <= seed;
                    control <= initial_code(strategy_e'(strategy), fixed_ctrl);
                    busy    <= 1'b1;
                    state   <= LOAD;
                end
                LOAD: begin
                    INIT  <= 1'b0;
                    state <= PLAY;
                end
                PLAY: begin
                    cyc <= cyc + 1'b1;
                    if (stop) begin
                        result  <= NONE;
                        control <= UP1;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end else if (gameover || cyc == LAST) begin
                        result  <= gameover ? who : TIMEOUT;
                        done    <= 1'b1;
                        control <= UP1;
                        state   <= DONE;
                    end else if (strat == BOUNCE && (win || los))
                        control <= win ? DN1 : UP1;
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    sat_counter #(.W(EVT_W)) u_win_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (clr),
        .inc     (play && win),
        .cnt     (win_cnt)
    );

    sat_counter #(.W(EVT_W)) u_los_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (clr),
        .inc     (play && los),
        .cnt     (los_cnt)
    );

endmodule

// File: tb/tb_game_player.sv
// tb_game_player: drives game_player against a behavioural counter game and random win/loss traffic.
module tb_game_player;
    import game_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n, start, stop, start_t;
    logic [1:0] strategy, fixed_ctrl, who;
    logic [3:0] seed;
    logic       win, los, gameover;
    logic [1:0] control, result, control_t, result_t;
    logic       INIT, busy, done, INIT_t, busy_t, done_t;
    logic [3:0] i_value, i_value_t;
    logic [7:0] win_cnt, los_cnt, win_cnt_t, los_cnt_t;

    logic       use_model, r_win, r_los, r_go;
    logic [1:0] r_who;
    logic [3:0] g_cnt, g_seed, g_nxt;
    int         g_w, g_l;
    logic       g_win, g_los, g_over;
    logic [1:0] g_who;

    assign win      = use_model ? g_win  : r_win;
    assign los      = use_model ? g_los  : r_los;
    assign gameover = use_model ? g_over : r_go;
    assign who      = use_model ? g_who  : r_who;

    game_player dut (
        .clk(clk), .reset_n(reset_n), .start(start), .stop(stop), .strategy(strategy),
        .fixed_ctrl(fixed_ctrl), .seed(seed), .win(win), .los(los), .gameover(gameover),
        .who(who), .control(control), .INIT(INIT), .i_value(i_value), .busy(busy),
        .done(done), .result(result), .win_cnt(win_cnt), .los_cnt(los_cnt)
    );

    game_player #(.MAX_CYCLES(32)) dut_t (
        .clk(clk), .reset_n(reset_n), .start(start_t), .stop(1'b0), .strategy(strategy),
        .fixed_ctrl(fixed_ctrl), .seed(seed), .win(1'b0), .los(1'b0), .gameover(1'b0),
        .who(2'b00), .control(control_t), .INIT(INIT_t), .i_value(i_value_t), .busy(busy_t),
        .done(done_t), .result(result_t), .win_cnt(win_cnt_t), .los_cnt(los_cnt_t)
    );

    // Counter game: step by control, win at all-ones, lose at zero, reload seed after each; 15 of either ends it.
    assign g_nxt = control[1] ? g_cnt - (control[0] ? 4'd2 : 4'd1) : g_cnt + (control[0] ? 4'd2 : 4'd1);

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            g_cnt <= '0; g_seed <= '0; g_w <= 0; g_l <= 0;
            g_win <= 1'b0; g_los <= 1'b0; g_over <= 1'b0; g_who <= '0;
        end else if (INIT) begin
            g_cnt <= i_value; g_seed <= i_value; g_w <= 0; g_l <= 0;
            g_win <= 1'b0; g_los <= 1'b0; g_over <= 1'b0; g_who <= '0;
        end else if (g_over) begin
            g_win <= 1'b0; g_los <= 1'b0;
        end else begin
            g_win <= g_nxt == 4'hf;
            g_los <= g_nxt == 4'h0;
            g_cnt <= (g_nxt == 4'hf || g_nxt == 4'h0) ? g_seed : g_nxt;
            if (g_nxt == 4'hf) begin
                g_w <= g_w + 1;
                if (g_w == 14) begin g_over <= 1'b1; g_who <= 2'b10; end
            end
            if (g_nxt == 4'h0) begin
                g_l <= g_l + 1;
                if (g_l == 14) begin g_over <= 1'b1; g_who <= 2'b01; end
            end
        end
    end

    int total = 0;
    int bad = 0;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [1:0] init_ctl(logic [1:0] s, logic [1:0] f);
        return s == 2'd0 ? f : s == 2'd2 ? DN1 : UP1;
    endfunction

    task automatic begin_game(input logic [1:0] s, input logic [1:0] f, input logic [3:0] sd);
        strategy = s; fixed_ctrl = f; seed = sd; start = 1'b1;
        tick();
        start = 1'b0;
        chk("load_init", int'(INIT), 1);
        chk("load_busy", int'(busy), 1);
        chk("load_ival", int'(i_value), int'(sd));
        chk("load_ctrl", int'(control), int'(init_ctl(s, f)));
        chk("load_result", int'(result), 0);
        chk("load_wcnt", int'(win_cnt), 0);
        chk("load_lcnt", int'(los_cnt), 0);
        tick();
        chk("play_init", int'(INIT), 0);
        chk("play_busy", int'(busy), 1);
    endtask

    typedef struct {
        logic [1:0] s;
        logic [1:0] f;
        logic [3:0] sd;
        logic [1:0] res;
        int         w;
        int         l;
    } row_t;

    task automatic run_model(input row_t r);
        logic [1:0] ctl;
        logic pw, pl, pg;
        int n, errs, inits;
        use_model = 1'b1;
        begin_game(r.s, r.f, r.sd);
        ctl = init_ctl(r.s, r.f);
        n = 0; errs = 0; inits = 0; pg = 1'b0;
        while (done !== 1'b1 && n < 2000) begin
            pw = win; pl = los; pg = gameover;
            tick();
            n++;
            if (INIT) inits++;
            if (done !== 1'b1) begin
                if (r.s == 2'd3 && pw) ctl = DN1;
                else if (r.s == 2'd3 && pl) ctl = UP1;
                if (control !== ctl) errs++;
            end
        end
        chk("game_done", int'(done), 1);
        chk("done_after_gameover", int'(pg), 1);
        chk("game_result", int'(result), int'(r.res));
        chk("game_wcnt", int'(win_cnt), r.w);
        chk("game_lcnt", int'(los_cnt), r.l);
        chk("game_ctrl_errs", errs, 0);
        chk("game_extra_init", inits, 0);
        chk("done_ctrl", int'(control), 0);
        chk("done_busy", int'(busy), 1);
        tick();
        chk("post_done", int'(done), 0);
        chk("post_busy", int'(busy), 0);
    endtask

    task automatic rand_game(input int len, input bit all_win);
        logic [1:0] s, f, ctl, w;
        int ew, el, errs, r;
        use_model = 1'b0; r_win = 1'b0; r_los = 1'b0; r_go = 1'b0;
        s = 2'($urandom_range(0, 3));
        f = 2'($urandom_range(0, 3));
        begin_game(s, f, 4'($urandom_range(0, 15)));
        ctl = init_ctl(s, f);
        ew = 0; el = 0; errs = 0;
        for (int k = 0; k < len; k++) begin
            r = all_win ? 0 : int'($urandom_range(0, 3));
            r_win = r == 0;
            r_los = r == 1;
            strategy = 2'($urandom_range(0, 3));
            fixed_ctrl = 2'($urandom_range(0, 3));
            seed = 4'($urandom_range(0, 15));
            start = $urandom_range(0, 7) == 0;
            if (control !== ctl) errs++;
            if (INIT !== 1'b0 || busy !== 1'b1 || done !== 1'b0) errs++;
            tick();
            if (r_win && ew < 255) ew++;
            if (r_los && el < 255) el++;
            if (s == 2'd3 && r_win) ctl = DN1;
            else if (s == 2'd3 && r_los) ctl = UP1;
        end
        start = 1'b0; r_win = 1'b0; r_los = 1'b0;
        w = 2'($urandom_range(0, 3));
        r_go = 1'b1; r_who = w;
        tick();
        r_go = 1'b0;
        chk("rnd_play_errs", errs, 0);
        chk("rnd_done", int'(done), 1);
        chk("rnd_result", int'(result), int'(w));
        chk("rnd_wcnt", int'(win_cnt), ew);
        chk("rnd_lcnt", int'(los_cnt), el);
        chk("rnd_done_ctrl", int'(control), 0);
        tick();
        chk("rnd_post_done", int'(done), 0);
        chk("rnd_post_busy", int'(busy), 0);
        tick();
        chk("rnd_result_held", int'(result), int'(w));
    endtask

    row_t rows[6];

    initial begin
        int n, errs;
        rows[0] = '{2'd1, 2'd0, 4'd14, 2'b10, 15, 0};
        rows[1] = '{2'd2, 2'd0, 4'd1,  2'b01, 0, 15};
        rows[2] = '{2'd0, 2'd1, 4'd0,  2'b01, 0, 15};
        rows[3] = '{2'd3, 2'd0, 4'd8,  2'b10, 15, 14};
        rows[4] = '{2'd0, 2'd3, 4'd5,  2'b10, 15, 0};
        rows[5] = '{2'd0, 2'd2, 4'd7,  2'b01, 0, 15};

        reset_n = 1'b0; start = 1'b0; stop = 1'b0; start_t = 1'b0;
        strategy = '0; fixed_ctrl = '0; seed = '0;
        use_model = 1'b0; r_win = 1'b0; r_los = 1'b0; r_go = 1'b0; r_who = '0;
        tick();
        tick();
        chk("rst_control", int'(control), 0);
        chk("rst_init", int'(INIT), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_result", int'(result), 0);
        chk("rst_wcnt", int'(win_cnt), 0);
        reset_n = 1'b1;
        tick();

        for (int i = 0; i < 6; i++) run_model(rows[i]);
        for (int i = 0; i < 6; i++) rand_game(int'($urandom_range(5, 60)), 1'b0);
        rand_game(300, 1'b1);

        // Abort mid-game: no done pulse, result cleared.
        use_model = 1'b0;
        begin_game(2'd1, 2'd0, 4'd5);
        tick();
        tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("stop_busy", int'(busy), 0);
        chk("stop_result", int'(result), 0);
        chk("stop_done", int'(done), 0);
        errs = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (done !== 1'b0 || busy !== 1'b0) errs++;
        end
        chk("stop_quiet", errs, 0);

        // Asynchronous reset in the middle of PLAY.
        begin_game(2'd3, 2'd0, 4'd9);
        r_win = 1'b1;
        tick();
        tick();
        r_win = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("arst_control", int'(control), 0);
        chk("arst_init", int'(INIT), 0);
        chk("arst_ival", int'(i_value), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_done", int'(done), 0);
        chk("arst_result", int'(result), 0);
        chk("arst_wcnt", int'(win_cnt), 0);
        chk("arst_lcnt", int'(los_cnt), 0);
        #2;
        reset_n = 1'b1;
        tick();
        rand_game(20, 1'b0);

        // Timeout on the 32-cycle instance with gameover never asserted.
        strategy = 2'd1; fixed_ctrl = 2'd0; seed = 4'd3; start_t = 1'b1;
        tick();
        start_t = 1'b0;
        n = 1;
        chk("to_init", int'(INIT_t), 1);
        while (done_t !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        chk("to_latency", n, 34);
        chk("to_result", int'(result_t), 3);
        chk("to_busy", int'(busy_t), 1);
        tick();
        chk("to_post_done", int'(done_t), 0);
        chk("to_post_busy", int'(busy_t), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
